// File: rtl/xof.sv
// Operand-fetch stage: holds one decoded instruction, reads the register file,
// forwards same-edge writebacks and blocks issue on scoreboard hazards.
module xof (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [4:0]  dec_ra_i,
    input  logic [4:0]  dec_rb_i,
    input  logic [4:0]  dec_rd_i,
    input  logic [31:0] dec_ctl_i,
    output logic [4:0]  ra_o,
    output logic [4:0]  rb_o,
    input  logic [63:0] rdata_i,
    input  logic [63:0] rdatb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [63:0] wb_dat_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [63:0] ex_a_o,
    output logic [63:0] ex_b_o,
    output logic [4:0]  ex_rd_o,
    output logic [31:0] ex_ctl_o,
    output logic [31:0] stall_cnt_o
);

    logic        valid_q;
    logic [4:0]  ra_q;
    logic [4:0]  rb_q;
    logic [4:0]  rd_q;
    logic [31:0] ctl_q;
    logic [31:1] busy_q;
    logic        fwda_q;
    logic        fwdb_q;
    logic [63:0] fwdadat_q;
    logic [63:0] fwdbdat_q;
    logic [31:0] stall_q;

    logic [31:0] busy_all;
    logic [31:0] busy_nxt;
    logic        dec_xfer;
    logic        issue;
    logic        wb_live;

    assign busy_all = {busy_q, 1'b0};
    assign wb_live  = wb_we_i && (wb_rd_i != '0);

    // Issue qualification uses only held state, never ex_ready_i.
    assign ex_valid_o  = valid_q && !busy_all[ra_q] && !busy_all[rb_q] && !busy_all[rd_q];
    assign issue       = ex_valid_o && ex_ready_i;
    assign dec_ready_o = !valid_q || issue;
    assign dec_xfer    = dec_valid_i && dec_ready_o;

    assign ra_o = dec_xfer ? dec_ra_i : ra_q;
    assign rb_o = dec_xfer ? dec_rb_i : rb_q;

    assign ex_a_o      = fwda_q ? fwdadat_q : rdata_i;
    assign ex_b_o      = fwdb_q ? fwdbdat_q : rdatb_i;
    assign ex_rd_o     = rd_q;
    assign ex_ctl_o    = ctl_q;
    assign stall_cnt_o = stall_q;

    // Clear first so that a same-edge set of the same register wins.
    always_comb begin
        busy_nxt = busy_all;
        if (wb_live) begin
            busy_nxt[wb_rd_i] = 1'b0;
        end
        if (issue && (rd_q != '0)) begin
            busy_nxt[rd_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            ctl_q   <= '0;
        end else if (dec_xfer) begin
            valid_q <= 1'b1;
            ra_q    <= dec_ra_i;
            rb_q    <= dec_rb_i;
            rd_q    <= dec_rd_i;
            ctl_q   <= dec_ctl_i;
        end else if (issue) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt[31:1];
        end
    end

    // The register file returns pre-write data on a same-edge write, so capture it here.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fwda_q    <= 1'b0;
            fwdb_q    <= 1'b0;
            fwdadat_q <= '0;
            fwdbdat_q <= '0;
        end else begin
            fwda_q    <= wb_live && (wb_rd_i == ra_o);
            fwdb_q    <= wb_live && (wb_rd_i == rb_o);
            fwdadat_q <= wb_dat_i;
            fwdbdat_q <= wb_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_q <= '0;
        end else if (valid_q && !ex_valid_o && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

endmodule

// File: doc/xof.md
XOF -- requirements
Module: xof

Interface
REQ-001 clk_i  in  1  processor clock; all state updates on rising edge.
REQ-002 reset_ni  in  1  reset, asynchronous, active-low.
REQ-003 dec_valid_i  in  1 / dec_ready_o  out  1  decode-side handshake; a transfer occurs when both are 1 at a clock edge.
REQ-004 dec_ra_i, dec_rb_i, dec_rd_i  in  5 each  source A, source B and destination register numbers.
REQ-005 dec_ctl_i  in  32  opaque control word, passed through unchanged.
REQ-006 ra_o, rb_o  out  5 each  read addresses to the register file (synchronous read, data valid one cycle after the address edge, x0 reads 0).
REQ-007 rdata_i, rdatb_i  in  64 each  register file read data.
REQ-008 wb_we_i  in  1 / wb_rd_i  in  5 / wb_dat_i  in  64  writeback port, identical to the register file write signals.
REQ-009 ex_valid_o  out  1 / ex_ready_i  in  1  execute-side handshake; an issue occurs when both are 1 at an edge.
REQ-010 ex_a_o, ex_b_o  out  64 / ex_rd_o  out  5 / ex_ctl_o  out  32  operands and passthrough fields.
REQ-011 stall_cnt_o  out  32  count of hazard-stall cycles.

Function
REQ-012 Holding stage: valid_q, ra_q, rb_q, rd_q, ctl_q; a decode transfer loads them from dec_* and sets valid_q.
REQ-013 An issue without a same-edge decode transfer clears valid_q.
REQ-014 dec_ready_o SHALL be !valid_q | (ex_valid_o & ex_ready_i), combinational; back-to-back throughput is one instruction per cycle.
REQ-015 ra_o/rb_o SHALL be dec_ra_i/dec_rb_i during a decode transfer cycle, else ra_q/rb_q; while stalled the register file is re-read every cycle.
REQ-016 Forward capture, every edge: fwda_q <= wb_we_i & (wb_rd_i == ra_o) & (ra_o != 0); fwdadat_q <= wb_dat_i; likewise fwdb_q/fwdbdat_q with rb_o.
REQ-017 ex_a_o SHALL be fwda_q ? fwdadat_q : rdata_i; ex_b_o likewise; ex_rd_o = rd_q; ex_ctl_o = ctl_q.
REQ-018 Scoreboard busy[31:1]; busy[0] is constant 0.
REQ-019 An issue with ex_rd_o != 0 sets busy[ex_rd_o].
REQ-020 wb_we_i with wb_rd_i != 0 clears busy[wb_rd_i].
REQ-021 When a set and a clear of the same bit occur on the same edge, set wins.
REQ-022 ex_valid_o SHALL be valid_q & !busy[ra_q] & !busy[rb_q] & !busy[rd_q]; no combinational path from ex_ready_i to ex_valid_o.
REQ-023 Operand latency: the first cycle ex_valid_o can assert is one edge after the decode transfer.
REQ-024 A writeback on the same edge that clears a busy bit is delivered by forwarding (REQ-016), never by stale register file data.
REQ-025 stall_cnt_o increments by 1 on each edge where valid_q & !ex_valid_o, and saturates at 0xFFFFFFFF.
REQ-026 A writeback to x0 SHALL neither forward nor alter the scoreboard.

Reset
REQ-027 While reset_ni=0, immediately:
- valid_q, busy, fwda_q and fwdb_q are 0.
- ra_q, rb_q, rd_q, ctl_q and the forward data registers are 0.
- stall_cnt_o is 0.
- Resulting outputs: ex_valid_o=0, dec_ready_o=1, ra_o=dec_ra_i only during a decode transfer, else 0.
REQ-028 Reset mid-operation discards the held instruction and all pending busy bits; no issue occurs on the edge of reset release.

Verification
REQ-029 Independent ops: x1=0x11, x2=0x22; issue add x3,x1,x2 then add x4,x1,x1 back-to-back with ex_ready_i=1 -> issued on consecutive cycles; operands (0x11,0x22) then (0x11,0x11); stall_cnt_o=0.
REQ-030 RAW hazard: issue rd=x5; next instruction reads x5; hold wb for 3 cycles, then wb x5=0xDEADBEEF -> second instruction stalls 3 cycles; it issues the cycle after wb with ex_a_o=0xDEADBEEF via forwarding; stall_cnt_o=3.
REQ-031 Write-during-read: decode transfer reading x7 on the same edge as wb x7=0x1234 (x7 not busy) -> ex_a_o=0x1234, not the old value.
REQ-032 Set/clear collision: wb x6 on the same edge that issues a new rd=x6 -> busy[6]=1 afterward; a following reader of x6 stalls.
REQ-033 Backpressure and reset: hold ex_ready_i=0 with a valid instruction for 5 cycles -> outputs stable, dec_ready_o=0; assert reset_ni=0 mid-stall -> ex_valid_o=0 and dec_ready_o=1 immediately; busy all 0.
REQ-034 x0 cases: wb x0=0xFF -> no forward and no busy change; an instruction with rd=x0 never stalls a later reader of x0.
